icache_ctrl_param: RTL and testbench

Parametrised, clocked, blocking set-associative instruction cache controller; the next generation of our L1 I-cache. It sits between the ITLB (physical fetch address) and the IFU (line data) and issues line refills to the L2 cache on a miss. It generalises sets, ways and line width, and adds round-robin replacement, a flush-all input and hit/miss counters.

---
 rtl/icache_ctrl_param_if.sv | 40 ++++
 rtl/icache_ctrl_param.sv | 164 ++++++++++++++++
 tb/tb_icache_ctrl_param.sv | 480 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/icache_ctrl_param_if.sv
// Fetch, L2 refill and IFU response signals of the instruction cache controller.
// Every channel uses valid/ready: a transfer happens on a rising clk edge where both are high,
// and a raised valid (with its payload) is held unchanged until that transfer.
interface icache_ctrl_param_if #(
  parameter int PA_W       = 34,
  parameter int LINE_BYTES = 32,
  parameter int CNT_W      = 16
);
  logic                    i_Itlb_valid;
  logic                    o_Itlb_ready;
  logic [PA_W-1:0]         i_Itlb_PA;
  logic                    i_flush;
  logic                    o_L2Cache_req_valid;
  logic                    i_L2Cache_req_ready;
  logic [PA_W-1:0]         o_miss_Addr_to_L2cache;
  logic                    i_L2Cache_refill_valid;
  logic                    o_L2Cache_refill_ready;
  logic [LINE_BYTES*8-1:0] i_L2Cache_refillLine;
  logic                    o_ifu_valid;
  logic                    i_ifu_ready;
  logic [LINE_BYTES*8-1:0] o_hit_data_to_ifu;
  logic [CNT_W-1:0]        o_hit_count;
  logic [CNT_W-1:0]        o_miss_count;

  modport slave (
    input  i_Itlb_valid, i_Itlb_PA, i_flush, i_L2Cache_req_ready,
           i_L2Cache_refill_valid, i_L2Cache_refillLine, i_ifu_ready,
    output o_Itlb_ready, o_L2Cache_req_valid, o_miss_Addr_to_L2cache,
           o_L2Cache_refill_ready, o_ifu_valid, o_hit_data_to_ifu,
           o_hit_count, o_miss_count
  );

  modport master (
    output i_Itlb_valid, i_Itlb_PA, i_flush, i_L2Cache_req_ready,
           i_L2Cache_refill_valid, i_L2Cache_refillLine, i_ifu_ready,
    input  o_Itlb_ready, o_L2Cache_req_valid, o_miss_Addr_to_L2cache,
           o_L2Cache_refill_ready, o_ifu_valid, o_hit_data_to_ifu,
           o_hit_count, o_miss_count
  );
endinterface

// File: rtl/icache_ctrl_param.sv
// Blocking set-associative L1 instruction cache controller: one outstanding fetch,
// L2 line refill on miss, round-robin replacement, flush-all and hit/miss counters.
module icache_ctrl_param #(
  parameter int PA_W       = 34,
  parameter int LINE_BYTES = 32,
  parameter int SETS       = 128,
  parameter int WAYS       = 4,
  parameter int CNT_W      = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  icache_ctrl_param_if.slave   bus,
  output logic [2:0]           dbg_state
);
  localparam int LINE_W = LINE_BYTES * 8;
  localparam int OFF_W  = $clog2(LINE_BYTES);
  localparam int IDX_W  = $clog2(SETS);
  localparam int TAG_W  = PA_W - IDX_W - OFF_W;
  localparam int WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    LOOKUP      = 3'd1,
    MISS_REQ    = 3'd2,
    REFILL_WAIT = 3'd3,
    RESP        = 3'd4
  } state_t;

  state_t             state;
  logic [PA_W-1:0]    pa_q;
  logic               flush_pend;
  logic               itlb_ready;

  logic               valid_q [SETS][WAYS];
  logic [TAG_W-1:0]   tag_q   [SETS][WAYS];
  logic [LINE_W-1:0]  data_q  [SETS][WAYS];
  logic [WAY_W-1:0]   rr_q    [SETS];

  logic [IDX_W-1:0]   cur_idx;
  logic [TAG_W-1:0]   cur_tag;
  logic               hit;
  logic [WAY_W-1:0]   hit_way;
  logic               any_invalid;
  logic [WAY_W-1:0]   victim;
  logic               refill_fire;

  assign cur_idx     = pa_q[IDX_W+OFF_W-1:OFF_W];
  assign cur_tag     = pa_q[PA_W-1:IDX_W+OFF_W];
  assign refill_fire = (state == REFILL_WAIT) && bus.i_L2Cache_refill_valid;

  // A pending or arriving flush must be applied before the next fetch is taken.
  assign itlb_ready       = (state == IDLE) && !bus.i_flush && !flush_pend && !rst;
  assign bus.o_Itlb_ready = itlb_ready;
  assign dbg_state        = 3'(state);

  always_comb begin
    hit         = 1'b0;
    hit_way     = '0;
    any_invalid = 1'b0;
    victim      = rr_q[cur_idx];
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[cur_idx][w] && (tag_q[cur_idx][w] == cur_tag)) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
    end
    // Descending scan so the lowest-numbered invalid way wins.
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid_q[cur_idx][w]) begin
        any_invalid = 1'b1;
        victim      = WAY_W'(w);
      end
    end
  end

  // Tag and line storage need no reset: every read is qualified by valid_q.
  always_ff @(posedge clk) begin
    if (refill_fire) begin
      tag_q[cur_idx][victim]  <= cur_tag;
      data_q[cur_idx][victim] <= bus.i_L2Cache_refillLine;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state                      <= IDLE;
      pa_q                       <= '0;
      flush_pend                 <= 1'b0;
      bus.o_L2Cache_req_valid    <= 1'b0;
      bus.o_miss_Addr_to_L2cache <= '0;
      bus.o_L2Cache_refill_ready <= 1'b0;
      bus.o_ifu_valid            <= 1'b0;
      bus.o_hit_data_to_ifu      <= '0;
      bus.o_hit_count            <= '0;
      bus.o_miss_count           <= '0;
      for (int s = 0; s < SETS; s++) begin
        rr_q[s] <= '0;
        for (int w = 0; w < WAYS; w++) valid_q[s][w] <= 1'b0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (bus.i_Itlb_valid && itlb_ready) begin
            pa_q  <= bus.i_Itlb_PA;
            state <= LOOKUP;
          end
        end
        LOOKUP: begin
          if (hit) begin
            bus.o_hit_data_to_ifu <= data_q[cur_idx][hit_way];
            bus.o_hit_count       <= bus.o_hit_count + CNT_W'(1);
            bus.o_ifu_valid       <= 1'b1;
            state                 <= RESP;
          end else begin
            bus.o_miss_count           <= bus.o_miss_count + CNT_W'(1);
            bus.o_miss_Addr_to_L2cache <= pa_q & ~PA_W'(LINE_BYTES - 1);
            bus.o_L2Cache_req_valid    <= 1'b1;
            state                      <= MISS_REQ;
          end
        end
        MISS_REQ: begin
          if (bus.i_L2Cache_req_ready) begin
            bus.o_L2Cache_req_valid    <= 1'b0;
            bus.o_L2Cache_refill_ready <= 1'b1;
            state                      <= REFILL_WAIT;
          end
        end
        REFILL_WAIT: begin
          if (bus.i_L2Cache_refill_valid) begin
            valid_q[cur_idx][victim]   <= 1'b1;
            if (!any_invalid) begin
              rr_q[cur_idx] <= (rr_q[cur_idx] == WAY_W'(WAYS - 1)) ? '0
                                                                    : rr_q[cur_idx] + WAY_W'(1);
            end
            bus.o_L2Cache_refill_ready <= 1'b0;
            bus.o_hit_data_to_ifu      <= bus.i_L2Cache_refillLine;
            bus.o_ifu_valid            <= 1'b1;
            state                      <= RESP;
          end
        end
        RESP: begin
          if (bus.i_ifu_ready) begin
            bus.o_ifu_valid <= 1'b0;
            state           <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase

      // Flush is deferred to IDLE so an in-flight refill lands first and is then wiped.
      if (bus.i_flush) begin
        flush_pend <= 1'b1;
      end else if ((state == IDLE) && flush_pend) begin
        flush_pend <= 1'b0;
      end
      if ((state == IDLE) && flush_pend) begin
        for (int s = 0; s < SETS; s++) begin
          rr_q[s] <= '0;
          for (int w = 0; w < WAYS; w++) valid_q[s][w] <= 1'b0;
        end
      end
    end
  end
endmodule

// File: tb/tb_icache_ctrl_param.sv
// Directed bench for icache_ctrl_param: cold miss, hit, back-to-back hits, IFU backpressure,
// conflict replacement, flush during refill and asynchronous reset during refill.
module tb_icache_ctrl_param;
  localparam int PA_W   = 34;
  localparam int LINE_W = 256;
  localparam int CNT_W  = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] dbg_state;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [LINE_W-1:0] exp_q [$];
  logic [CNT_W-1:0]  exp_hits;
  logic [CNT_W-1:0]  exp_misses;

  localparam logic [PA_W-1:0]   PA0   = 34'h234567_abc;
  localparam logic [LINE_W-1:0] LINE0 =
    256'hfea5bf5c_13579bdf_2468ace0_0badf00d_deadbeef_cafef00d_a5a5c3c3_5e91b527;

  icache_ctrl_param_if #(.PA_W(PA_W), .LINE_BYTES(32), .CNT_W(CNT_W)) bus ();

  icache_ctrl_param #(
    .PA_W(PA_W), .LINE_BYTES(32), .SETS(128), .WAYS(4), .CNT_W(CNT_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus.slave),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    tests_failed++;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  function automatic logic [LINE_W-1:0] line_for(input logic [21:0] tag);
    return {8{10'h2d5, tag}};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic send_req(input logic [PA_W-1:0] pa, output bit acc);
    int n;
    n = 0;
    bus.i_Itlb_valid = 1'b1;
    bus.i_Itlb_PA    = pa;
    while (!bus.o_Itlb_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    acc = bus.o_Itlb_ready;
    @(posedge clk); #1;
    bus.i_Itlb_valid = 1'b0;
  endtask

  task automatic run_txn(input logic [PA_W-1:0] pa, input logic [LINE_W-1:0] line,
                         output bit saw_miss, output logic [PA_W-1:0] addr,
                         output logic [LINE_W-1:0] data, output bit ok);
    bit acc;
    saw_miss = 1'b0;
    addr     = '0;
    data     = '0;
    ok       = 1'b0;
    send_req(pa, acc);
    if (acc) begin
      for (int c = 0; c < 40 && !ok; c++) begin
        @(posedge clk); #1;
        if (bus.o_ifu_valid) begin
          data            = bus.o_hit_data_to_ifu;
          bus.i_ifu_ready = 1'b1;
          @(posedge clk); #1;
          bus.i_ifu_ready = 1'b0;
          ok              = 1'b1;
        end else if (bus.o_L2Cache_req_valid) begin
          saw_miss                = 1'b1;
          addr                    = bus.o_miss_Addr_to_L2cache;
          bus.i_L2Cache_req_ready = 1'b1;
          @(posedge clk); #1;
          bus.i_L2Cache_req_ready    = 1'b0;
          bus.i_L2Cache_refill_valid = 1'b1;
          bus.i_L2Cache_refillLine   = line;
          @(posedge clk); #1;
          bus.i_L2Cache_refill_valid = 1'b0;
        end
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    tests_run++;
    if (bus.o_Itlb_ready !== 1'b1 || bus.o_L2Cache_req_valid !== 1'b0 ||
        bus.o_L2Cache_refill_ready !== 1'b0 || bus.o_ifu_valid !== 1'b0 || dbg_state !== 3'd0) begin
      $display("FAIL reset_ctrl: got rdy=%b req=%b rfr=%b ifu=%b st=%0d required 1 0 0 0 0",
               bus.o_Itlb_ready, bus.o_L2Cache_req_valid, bus.o_L2Cache_refill_ready,
               bus.o_ifu_valid, dbg_state);
      tests_failed++;
    end
    tests_run++;
    if (bus.o_hit_count !== 16'd0 || bus.o_miss_count !== 16'd0 ||
        bus.o_miss_Addr_to_L2cache !== 34'd0 || bus.o_hit_data_to_ifu !== 256'd0) begin
      $display("FAIL reset_data: got hits=%0d misses=%0d addr=%h required zeros",
               bus.o_hit_count, bus.o_miss_count, bus.o_miss_Addr_to_L2cache);
      tests_failed++;
    end
  endtask

  task automatic test_cold_miss;
    logic [LINE_W-1:0] exp;
    bus.i_Itlb_valid = 1'b1;
    bus.i_Itlb_PA    = PA0;
    exp_q.push_back(LINE0);
    @(posedge clk); #1;
    bus.i_Itlb_valid = 1'b0;
    tests_run++;
    if (bus.o_L2Cache_req_valid !== 1'b0 || dbg_state !== 3'd1) begin
      $display("FAIL cold_lookup: got req=%b st=%0d required 0 1", bus.o_L2Cache_req_valid, dbg_state);
      tests_failed++;
    end
    @(posedge clk); #1;
    exp_misses++;
    tests_run++;
    if (bus.o_L2Cache_req_valid !== 1'b1 || bus.o_miss_Addr_to_L2cache !== 34'h234567_aa0) begin
      $display("FAIL cold_req: got req=%b addr=%h required 1 234567aa0",
               bus.o_L2Cache_req_valid, bus.o_miss_Addr_to_L2cache);
      tests_failed++;
    end
    bus.i_L2Cache_refill_valid = 1'b1;
    bus.i_L2Cache_refillLine   = ~LINE0;
    repeat (2) @(posedge clk);
    #1;
    tests_run++;
    if (bus.o_L2Cache_req_valid !== 1'b1 || bus.o_miss_Addr_to_L2cache !== 34'h234567_aa0 ||
        bus.o_L2Cache_refill_ready !== 1'b0 || bus.o_ifu_valid !== 1'b0) begin
      $display("FAIL cold_req_hold: got req=%b addr=%h rfr=%b ifu=%b required 1 234567aa0 0 0",
               bus.o_L2Cache_req_valid, bus.o_miss_Addr_to_L2cache,
               bus.o_L2Cache_refill_ready, bus.o_ifu_valid);
      tests_failed++;
    end
    bus.i_L2Cache_refill_valid = 1'b0;
    bus.i_L2Cache_req_ready    = 1'b1;
    @(posedge clk); #1;
    bus.i_L2Cache_req_ready = 1'b0;
    tests_run++;
    if (bus.o_L2Cache_refill_ready !== 1'b1 || bus.o_L2Cache_req_valid !== 1'b0) begin
      $display("FAIL cold_refill_wait: got rfr=%b req=%b required 1 0",
               bus.o_L2Cache_refill_ready, bus.o_L2Cache_req_valid);
      tests_failed++;
    end
    bus.i_L2Cache_refill_valid = 1'b1;
    bus.i_L2Cache_refillLine   = LINE0;
    @(posedge clk); #1;
    bus.i_L2Cache_refill_valid = 1'b0;
    exp = exp_q.pop_front();
    tests_run++;
    if (bus.o_ifu_valid !== 1'b1 || bus.o_hit_data_to_ifu !== exp ||
        bus.o_miss_count !== exp_misses || bus.o_hit_count !== exp_hits) begin
      $display("FAIL cold_resp: got ifu=%b misses=%0d hits=%0d data=%h required 1 %0d %0d %h",
               bus.o_ifu_valid, bus.o_miss_count, bus.o_hit_count, bus.o_hit_data_to_ifu,
               exp_misses, exp_hits, exp);
      tests_failed++;
    end
    bus.i_ifu_ready = 1'b1;
    @(posedge clk); #1;
    bus.i_ifu_ready = 1'b0;
    tests_run++;
    if (dbg_state !== 3'd0 || bus.o_ifu_valid !== 1'b0 || bus.o_Itlb_ready !== 1'b1) begin
      $display("FAIL cold_done: got st=%0d ifu=%b rdy=%b required 0 0 1",
               dbg_state, bus.o_ifu_valid, bus.o_Itlb_ready);
      tests_failed++;
    end
  endtask

  task automatic test_hit;
    logic [LINE_W-1:0] exp;
    exp_q.push_back(LINE0);
    bus.i_Itlb_valid = 1'b1;
    bus.i_Itlb_PA    = PA0;
    @(posedge clk); #1;
    bus.i_Itlb_valid = 1'b0;
    tests_run++;
    if (bus.o_ifu_valid !== 1'b0 || bus.o_L2Cache_req_valid !== 1'b0) begin
      $display("FAIL hit_lookup: got ifu=%b req=%b required 0 0", bus.o_ifu_valid, bus.o_L2Cache_req_valid);
      tests_failed++;
    end
    @(posedge clk); #1;
    exp_hits++;
    exp = exp_q.pop_front();
    tests_run++;
    if (bus.o_ifu_valid !== 1'b1 || bus.o_L2Cache_req_valid !== 1'b0 ||
        bus.o_hit_data_to_ifu !== exp || bus.o_hit_count !== exp_hits) begin
      $display("FAIL hit_resp: got ifu=%b req=%b hits=%0d data=%h required 1 0 %0d %h",
               bus.o_ifu_valid, bus.o_L2Cache_req_valid, bus.o_hit_count,
               bus.o_hit_data_to_ifu, exp_hits, exp);
      tests_failed++;
    end
    bus.i_ifu_ready = 1'b1;
    @(posedge clk); #1;
    bus.i_ifu_ready = 1'b0;
  endtask

  task automatic test_back_to_back;
    int accepts;
    accepts          = 0;
    bus.i_ifu_ready  = 1'b1;
    bus.i_Itlb_valid = 1'b1;
    bus.i_Itlb_PA    = PA0;
    for (int i = 0; i < 9; i++) begin
      if (bus.o_Itlb_ready) accepts++;
      @(posedge clk); #1;
    end
    bus.i_Itlb_valid = 1'b0;
    bus.i_ifu_ready  = 1'b0;
    exp_hits += 16'd3;
    tests_run++;
    if (accepts !== 3 || bus.o_hit_count !== exp_hits || dbg_state !== 3'd0) begin
      $display("FAIL b2b_rate: got accepts=%0d hits=%0d st=%0d required 3 %0d 0",
               accepts, bus.o_hit_count, dbg_state, exp_hits);
      tests_failed++;
    end
  endtask

  task automatic test_backpressure;
    bit acc;
    bit bad;
    bad = 1'b0;
    send_req(PA0, acc);
    @(posedge clk); #1;
    exp_hits++;
    tests_run++;
    if (!acc || bus.o_ifu_valid !== 1'b1 || bus.o_hit_data_to_ifu !== LINE0) begin
      $display("FAIL bp_first: got acc=%b ifu=%b data=%h required 1 1 %h",
               acc, bus.o_ifu_valid, bus.o_hit_data_to_ifu, LINE0);
      tests_failed++;
    end
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (bus.o_ifu_valid !== 1'b1 || bus.o_hit_data_to_ifu !== LINE0 || bus.o_Itlb_ready !== 1'b0)
        bad = 1'b1;
    end
    tests_run++;
    if (bad) begin
      $display("FAIL bp_hold: got unstable response or ready high, required ifu=1 data held rdy=0");
      tests_failed++;
    end
    bus.i_ifu_ready = 1'b1;
    @(posedge clk); #1;
    bus.i_ifu_ready = 1'b0;
    tests_run++;
    if (dbg_state !== 3'd0 || bus.o_Itlb_ready !== 1'b1 || bus.o_ifu_valid !== 1'b0) begin
      $display("FAIL bp_release: got st=%0d rdy=%b ifu=%b required 0 1 0",
               dbg_state, bus.o_Itlb_ready, bus.o_ifu_valid);
      tests_failed++;
    end
  endtask

  task automatic test_conflict;
    logic [21:0] tags [4];
    bit saw_miss, ok;
    logic [PA_W-1:0]   addr;
    logic [LINE_W-1:0] data, exp;
    tags[0] = 22'h256789; tags[1] = 22'h278901; tags[2] = 22'h29abcd; tags[3] = 22'h2bcdef;
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(line_for(tags[i]));
      run_txn({tags[i], 12'habc}, line_for(tags[i]), saw_miss, addr, data, ok);
      exp_misses++;
      exp = exp_q.pop_front();
      tests_run++;
      if (!ok || !saw_miss || addr !== {tags[i], 12'haa0} || data !== exp) begin
        $display("FAIL conflict_fill%0d: got ok=%b miss=%b addr=%h data=%h required 1 1 %h %h",
                 i, ok, saw_miss, addr, data, {tags[i], 12'haa0}, exp);
        tests_failed++;
      end
    end
    // Fifth tag evicted way 0, so the original line is gone; this refill then evicts way 1.
    run_txn(PA0, LINE0, saw_miss, addr, data, ok);
    exp_misses++;
    tests_run++;
    if (!ok || !saw_miss || data !== LINE0) begin
      $display("FAIL conflict_evicted: got ok=%b miss=%b required 1 1", ok, saw_miss);
      tests_failed++;
    end
    run_txn({tags[1], 12'habc}, '0, saw_miss, addr, data, ok);
    exp_hits++;
    tests_run++;
    if (!ok || saw_miss || data !== line_for(tags[1])) begin
      $display("FAIL conflict_way2_hit: got ok=%b miss=%b data=%h required 1 0 %h",
               ok, saw_miss, data, line_for(tags[1]));
      tests_failed++;
    end
    run_txn({tags[3], 12'habc}, '0, saw_miss, addr, data, ok);
    exp_hits++;
    tests_run++;
    if (!ok || saw_miss || data !== line_for(tags[3]) ||
        bus.o_hit_count !== exp_hits || bus.o_miss_count !== exp_misses) begin
      $display("FAIL conflict_way0_hit: got ok=%b miss=%b hits=%0d misses=%0d required 1 0 %0d %0d",
               ok, saw_miss, bus.o_hit_count, bus.o_miss_count, exp_hits, exp_misses);
      tests_failed++;
    end
  endtask

  task automatic test_flush_refill;
    logic [PA_W-1:0]   pa_f;
    logic [LINE_W-1:0] line_f;
    bit saw_miss, ok;
    logic [PA_W-1:0]   addr;
    logic [LINE_W-1:0] data;
    pa_f   = {22'h300000, 7'h10, 5'h04};
    line_f = line_for(22'h300000);
    bus.i_Itlb_valid = 1'b1;
    bus.i_Itlb_PA    = pa_f;
    @(posedge clk); #1;
    bus.i_Itlb_valid = 1'b0;
    @(posedge clk); #1;
    bus.i_L2Cache_req_ready = 1'b1;
    @(posedge clk); #1;
    bus.i_L2Cache_req_ready = 1'b0;
    exp_misses++;
    bus.i_flush = 1'b1;
    @(posedge clk); #1;
    bus.i_flush = 1'b0;
    tests_run++;
    if (dbg_state !== 3'd3 || bus.o_L2Cache_refill_ready !== 1'b1) begin
      $display("FAIL flush_in_refill: got st=%0d rfr=%b required 3 1", dbg_state, bus.o_L2Cache_refill_ready);
      tests_failed++;
    end
    @(posedge clk); #1;
    bus.i_L2Cache_refill_valid = 1'b1;
    bus.i_L2Cache_refillLine   = line_f;
    @(posedge clk); #1;
    bus.i_L2Cache_refill_valid = 1'b0;
    tests_run++;
    if (bus.o_ifu_valid !== 1'b1 || bus.o_hit_data_to_ifu !== line_f) begin
      $display("FAIL flush_resp: got ifu=%b data=%h required 1 %h",
               bus.o_ifu_valid, bus.o_hit_data_to_ifu, line_f);
      tests_failed++;
    end
    bus.i_ifu_ready = 1'b1;
    @(posedge clk); #1;
    bus.i_ifu_ready = 1'b0;
    tests_run++;
    if (dbg_state !== 3'd0 || bus.o_Itlb_ready !== 1'b0) begin
      $display("FAIL flush_pend_block: got st=%0d rdy=%b required 0 0", dbg_state, bus.o_Itlb_ready);
      tests_failed++;
    end
    @(posedge clk); #1;
    tests_run++;
    if (bus.o_Itlb_ready !== 1'b1) begin
      $display("FAIL flush_pend_clear: got rdy=%b required 1", bus.o_Itlb_ready);
      tests_failed++;
    end
    run_txn(pa_f, line_f, saw_miss, addr, data, ok);
    exp_misses++;
    tests_run++;
    if (!ok || !saw_miss || addr !== {22'h300000, 7'h10, 5'h00} ||
        bus.o_miss_count !== exp_misses || bus.o_hit_count !== exp_hits) begin
      $display("FAIL flush_refetch: got ok=%b miss=%b addr=%h misses=%0d hits=%0d required 1 1 %h %0d %0d",
               ok, saw_miss, addr, bus.o_miss_count, bus.o_hit_count,
               {22'h300000, 7'h10, 5'h00}, exp_misses, exp_hits);
      tests_failed++;
    end
    // A flush arriving together with a fetch in IDLE must block the fetch.
    bus.i_flush      = 1'b1;
    bus.i_Itlb_valid = 1'b1;
    bus.i_Itlb_PA    = pa_f;
    #1;
    tests_run++;
    if (bus.o_Itlb_ready !== 1'b0) begin
      $display("FAIL flush_vs_fetch_rdy: got rdy=%b required 0", bus.o_Itlb_ready);
      tests_failed++;
    end
    @(posedge clk); #1;
    bus.i_flush      = 1'b0;
    bus.i_Itlb_valid = 1'b0;
    tests_run++;
    if (dbg_state !== 3'd0) begin
      $display("FAIL flush_vs_fetch_state: got st=%0d required 0", dbg_state);
      tests_failed++;
    end
    @(posedge clk); #1;
    run_txn({22'h2bcdef, 12'habc}, '0, saw_miss, addr, data, ok);
    exp_misses++;
    tests_run++;
    if (!ok || !saw_miss || bus.o_miss_count !== exp_misses || bus.o_hit_count !== exp_hits) begin
      $display("FAIL flush_all_invalid: got ok=%b miss=%b misses=%0d hits=%0d required 1 1 %0d %0d",
               ok, saw_miss, bus.o_miss_count, bus.o_hit_count, exp_misses, exp_hits);
      tests_failed++;
    end
  endtask

  task automatic test_reset_refill;
    bit saw_miss, ok;
    logic [PA_W-1:0]   addr;
    logic [LINE_W-1:0] data;
    bus.i_Itlb_valid = 1'b1;
    bus.i_Itlb_PA    = {22'h111111, 7'h22, 5'h00};
    @(posedge clk); #1;
    bus.i_Itlb_valid = 1'b0;
    @(posedge clk); #1;
    bus.i_L2Cache_req_ready = 1'b1;
    @(posedge clk); #1;
    bus.i_L2Cache_req_ready = 1'b0;
    tests_run++;
    if (bus.o_L2Cache_refill_ready !== 1'b1) begin
      $display("FAIL rst_pre_refill: got rfr=%b required 1", bus.o_L2Cache_refill_ready);
      tests_failed++;
    end
    #2 rst = 1'b1;
    #1;
    exp_hits   = '0;
    exp_misses = '0;
    tests_run++;
    if (bus.o_Itlb_ready !== 1'b0 || bus.o_L2Cache_req_valid !== 1'b0 ||
        bus.o_L2Cache_refill_ready !== 1'b0 || bus.o_ifu_valid !== 1'b0 ||
        bus.o_hit_count !== exp_hits || bus.o_miss_count !== exp_misses ||
        bus.o_miss_Addr_to_L2cache !== 34'd0 || dbg_state !== 3'd0) begin
      $display("FAIL rst_async: got rdy=%b req=%b rfr=%b ifu=%b hits=%0d misses=%0d st=%0d required all 0",
               bus.o_Itlb_ready, bus.o_L2Cache_req_valid, bus.o_L2Cache_refill_ready,
               bus.o_ifu_valid, bus.o_hit_count, bus.o_miss_count, dbg_state);
      tests_failed++;
    end
    @(posedge clk); #1;
    rst = 1'b0;
    bus.i_L2Cache_refill_valid = 1'b1;
    bus.i_L2Cache_refillLine   = line_for(22'h111111);
    repeat (2) @(posedge clk);
    #1;
    tests_run++;
    if (bus.o_ifu_valid !== 1'b0 || bus.o_L2Cache_refill_ready !== 1'b0 || bus.o_Itlb_ready !== 1'b1) begin
      $display("FAIL rst_refill_ignored: got ifu=%b rfr=%b rdy=%b required 0 0 1",
               bus.o_ifu_valid, bus.o_L2Cache_refill_ready, bus.o_Itlb_ready);
      tests_failed++;
    end
    bus.i_L2Cache_refill_valid = 1'b0;
    run_txn(PA0, LINE0, saw_miss, addr, data, ok);
    exp_misses++;
    tests_run++;
    if (!ok || !saw_miss || data !== LINE0 || bus.o_miss_count !== exp_misses) begin
      $display("FAIL rst_cold_again: got ok=%b miss=%b misses=%0d required 1 1 %0d",
               ok, saw_miss, bus.o_miss_count, exp_misses);
      tests_failed++;
    end
  endtask

  // ---------------- sequence and final report ----------------
  initial begin
    rst                        = 1'b1;
    bus.i_Itlb_valid           = 1'b0;
    bus.i_Itlb_PA              = '0;
    bus.i_flush                = 1'b0;
    bus.i_L2Cache_req_ready    = 1'b0;
    bus.i_L2Cache_refill_valid = 1'b0;
    bus.i_L2Cache_refillLine   = '0;
    bus.i_ifu_ready            = 1'b0;
    exp_hits                   = '0;
    exp_misses                 = '0;
    #22 rst = 1'b0;
    @(posedge clk); #1;

    test_reset();
    test_cold_miss();
    test_hit();
    test_back_to_back();
    test_backpressure();
    test_conflict();
    test_flush_refill();
    test_reset_refill();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
